// File: rtl/mux_sel_stepper.sv
// mux_sel_stepper: turns a raw push-button and a raw auto-mode switch into a
// clean select value for the LED mux.
//
// Each debounced press advances sel by one. While auto mode is on, sel also
// advances every AUTO_PERIOD clocks. sel wraps modulo 2**SEL_W.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   rst_n      synchronous active-low reset
//   btn_step   raw asynchronous push-button, high = pressed
//   sw_auto    raw asynchronous auto-mode switch, high = auto on
//   sel_clr    synchronous clear of sel; already clean, has top priority
//   sel        current select value
//   step       one-cycle pulse in the first cycle sel shows its new value
//   btn_level  debounced button level
module mux_sel_stepper #(
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned AUTO_PERIOD = 5,
    parameter int unsigned SEL_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             sw_auto,
    input  logic             sel_clr,
    output logic [SEL_W-1:0] sel,
    output logic             step,
    output logic             btn_level
);

    localparam int unsigned DbW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned AutoW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
    localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressWait,
        StPressed,
        StReleaseWait
    } db_state_e;

    logic             btn_s1_q, btn_s2_q;
    logic             auto_s1_q, auto_s2_q;
    db_state_e        state_q, state_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             step_q, step_d;
    logic             btn_level_q, btn_level_d;
    logic             btn_press_evt;
    logic             auto_evt;

    // Debounce FSM: a level change is accepted only after btn_s2 has held the
    // new value through DB_CYCLES counted cycles. Only presses produce an event.
    always_comb begin
        state_d       = state_q;
        db_cnt_d      = db_cnt_q;
        btn_press_evt = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (btn_s2_q) begin
                    state_d  = StPressWait;
                    db_cnt_d = '0;
                end
            end
            StPressWait: begin
                if (!btn_s2_q) begin
                    state_d = StReleased;
                end else if (db_cnt_q == DbLast) begin
                    state_d       = StPressed;
                    btn_press_evt = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!btn_s2_q) begin
                    state_d  = StReleaseWait;
                    db_cnt_d = '0;
                end
            end
            StReleaseWait: begin
                if (btn_s2_q) begin
                    state_d = StPressed;
                end else if (db_cnt_q == DbLast) begin
                    state_d = StReleased;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReleased;
            end
        endcase
        btn_level_d = (state_d == StPressed) || (state_d == StReleaseWait);
    end

    // Auto counter: held at zero while disabled so each enable starts a full period.
    always_comb begin
        auto_cnt_d = '0;
        auto_evt   = 1'b0;
        if (auto_s2_q) begin
            if (auto_cnt_q == AutoLast) begin
                auto_evt = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + 1'b1;
            end
        end
    end

    // Select update; coincident button and auto events merge into one step.
    always_comb begin
        sel_d  = sel_q;
        step_d = 1'b0;
        if (sel_clr) begin
            sel_d = '0;
        end else if (btn_press_evt || auto_evt) begin
            sel_d  = sel_q + SEL_W'(1);
            step_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            auto_s1_q   <= 1'b0;
            auto_s2_q   <= 1'b0;
            state_q     <= StReleased;
            db_cnt_q    <= '0;
            auto_cnt_q  <= '0;
            sel_q       <= '0;
            step_q      <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            btn_s1_q    <= btn_step;
            btn_s2_q    <= btn_s1_q;
            auto_s1_q   <= sw_auto;
            auto_s2_q   <= auto_s1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            auto_cnt_q  <= auto_cnt_d;
            sel_q       <= sel_d;
            step_q      <= step_d;
            btn_level_q <= btn_level_d;
        end
    end

    assign sel       = sel_q;
    assign step      = step_q;
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_mux_sel_stepper.sv
// Bench for mux_sel_stepper: directed scenarios followed by a randomized run,
// all compared every cycle against a run-length reference model.
module tb_mux_sel_stepper;

    localparam int DB = 4;
    localparam int AP = 5;
    localparam int W  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn_step;
    logic         sw_auto;
    logic         sel_clr;
    logic [W-1:0] sel;
    logic         step;
    logic         btn_level;

    int errors = 0;
    int checks = 0;
    int step_cnt;

    // Reference model state
    logic m_b1, m_b2, m_a1, m_a2;
    logic m_lvl;
    int   m_run;   // consecutive cycles the synced button has disagreed with m_lvl
    int   m_arun;  // consecutive cycles auto mode has been seen enabled
    int   m_sel;
    logic m_step;

    mux_sel_stepper #(
        .DB_CYCLES  (DB),
        .AUTO_PERIOD(AP),
        .SEL_W      (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_step (btn_step),
        .sw_auto  (sw_auto),
        .sel_clr  (sel_clr),
        .sel      (sel),
        .step     (step),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the behavioural model, using input values held at the edge.
    task automatic model_edge();
        logic press, auto_ev;
        press   = 1'b0;
        auto_ev = 1'b0;
        if (!rst_n) begin
            {m_b1, m_b2, m_a1, m_a2, m_lvl, m_step} = '0;
            m_run  = 0;
            m_arun = 0;
            m_sel  = 0;
        end else begin
            // A new level is accepted on the (DB+1)th consecutive disagreeing cycle.
            if (m_b2 == m_lvl) begin
                m_run = 0;
            end else if (m_run == DB) begin
                press = !m_lvl;
                m_lvl = !m_lvl;
                m_run = 0;
            end else begin
                m_run++;
            end
            if (m_a2) begin
                m_arun++;
                auto_ev = (m_arun % AP) == 0;
            end else begin
                m_arun = 0;
            end
            if (sel_clr) begin
                m_sel  = 0;
                m_step = 1'b0;
            end else if (press || auto_ev) begin
                m_sel  = (m_sel + 1) % (1 << W);
                m_step = 1'b1;
            end else begin
                m_step = 1'b0;
            end
            m_b2 = m_b1;
            m_b1 = btn_step;
            m_a2 = m_a1;
            m_a1 = sw_auto;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (step === 1'b1) step_cnt++;
        check("model_sel", 32'(sel), 32'(m_sel));
        check("model_step", 32'(step), 32'(m_step));
        check("model_btn_level", 32'(btn_level), 32'(m_lvl));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold;
        int sel_before;
        rst_n    = 1'b0;
        btn_step = 1'b1;
        sw_auto  = 1'b1;
        sel_clr  = 1'b0;
        step_cnt = 0;
        #2;

        // Reset with both raw inputs high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_sel", 32'(sel), 0);
            check("reset_step", 32'(step), 0);
            check("reset_btn_level", 32'(btn_level), 0);
        end
        btn_step = 1'b0;
        sw_auto  = 1'b0;
        rst_n    = 1'b1;
        ticks(3);

        // Clean press held 20 clocks: one step after edge 7
        step_cnt = 0;
        btn_step = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 6) check("press_e6_step", 32'(step), 0);
            if (e == 7) begin
                check("press_e7_step", 32'(step), 1);
                check("press_e7_sel", 32'(sel), 1);
            end
            if (e == 8) check("press_e8_step", 32'(step), 0);
            if (e == 15) check("press_held_level", 32'(btn_level), 1);
        end
        check("press_step_count", 32'(step_cnt), 1);
        btn_step = 1'b0;
        ticks(10);
        check("release_level", 32'(btn_level), 0);

        // Bounce rejection
        step_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            btn_step = (i % 2 == 0);
            tick();
        end
        btn_step = 1'b0;
        ticks(10);
        check("bounce_steps", 32'(step_cnt), 0);
        check("bounce_sel", 32'(sel), 1);
        for (int p = 0; p < 3; p++) begin
            btn_step = 1'b1;
            ticks(10);
            btn_step = 1'b0;
            ticks(10);
        end
        check("three_press_sel", 32'(sel), 4);

        // Auto run from sel=0: steps at 7, 12, 17, ...; tenth step wraps to 2
        sel_clr = 1'b1;
        tick();
        sel_clr = 1'b0;
        check("clr_sel", 32'(sel), 0);
        ticks(3);
        step_cnt = 0;
        sw_auto  = 1'b1;
        for (int e = 1; e <= 52; e++) begin
            tick();
            if (e == 6 || e == 11) check("auto_gap_step", 32'(step), 0);
            if (e == 7 || e == 12 || e == 17) check("auto_step", 32'(step), 1);
        end
        check("auto_step_count", 32'(step_cnt), 10);
        check("auto_wrap_sel", 32'(sel), 2);
        sw_auto = 1'b0;
        ticks(5);

        // Auto dropped before edge 9: only the edge-7 step
        sel_clr = 1'b1;
        tick();
        sel_clr  = 1'b0;
        step_cnt = 0;
        sw_auto  = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 8) sw_auto = 1'b0;
            if (e == 12) check("auto_drop_e12_step", 32'(step), 0);
        end
        check("auto_drop_count", 32'(step_cnt), 1);
        check("auto_drop_sel", 32'(sel), 1);
        ticks(5);

        // Coincident press and auto events on edge 7
        sel_before = m_sel;
        btn_step   = 1'b1;
        sw_auto    = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 7) begin
                check("coinc_step", 32'(step), 1);
                check("coinc_sel", 32'(sel), 32'((sel_before + 1) % (1 << W)));
            end
            if (e == 8) check("coinc_step_off", 32'(step), 0);
        end
        btn_step = 1'b0;
        sw_auto  = 1'b0;
        ticks(15);

        // Clear beats the event that would take sel from 5 to 6
        sel_clr = 1'b1;
        tick();
        sel_clr = 1'b0;
        ticks(3);
        sw_auto = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 27) check("clr_pre_sel", 32'(sel), 5);
            if (e == 31) sel_clr = 1'b1;
            if (e == 32) begin
                check("clr_prio_sel", 32'(sel), 0);
                check("clr_prio_step", 32'(step), 0);
            end
        end
        sel_clr = 1'b0;
        sw_auto = 1'b0;
        ticks(5);

        // Reset in the middle of press debounce: no step afterwards
        btn_step = 1'b1;
        ticks(4);
        rst_n    = 1'b0;
        btn_step = 1'b0;
        ticks(2);
        rst_n    = 1'b1;
        step_cnt = 0;
        ticks(12);
        check("rst_pw_steps", 32'(step_cnt), 0);
        check("rst_pw_sel", 32'(sel), 0);

        // Randomized run
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                btn_step = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 19) == 0) sw_auto = !sw_auto;
            sel_clr = ($urandom_range(0, 39) == 0);
            rst_n   = !($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
